sram_boot_loader: RTL and testbench

Boot-time loader between the SLC-3 top level and the external SRAM pins. After reset, on a `Start` pulse it copies `INIT_WORDS` words from an on-chip synchronous ROM into SRAM starting at `BASE_ADDR`, holding the CPU off the bus with `Hold`. When the copy finishes it hands the SRAM bus back to the CPU's memory subsystem as a transparent pass-through.

---
 rtl/slc3_mem_pkg.sv | 35 +++
 rtl/sram_boot_loader_if.sv | 20 ++
 rtl/sram_bus_mux.sv | 23 ++
 rtl/sram_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_sram_boot_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared SRAM-side types for the SLC-3 memory path: loader FSM states,
// SRAM geometry and the active-low control bundle.
package slc3_mem_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WRITE,
      ST_RECOVER,
`ifdef SRAM_LOAD_VERIFY_EN
      ST_VFETCH,
      ST_VREAD,
`endif
      ST_DONE
   } loader_state_t;

   typedef struct packed {
      logic ce;
      logic ub;
      logic lb;
      logic oe;
      logic we;
   } sram_ctrl_t;

   localparam sram_ctrl_t CTRL_IDLE = '{ce: 1'b1, ub: 1'b1, lb: 1'b1, oe: 1'b1, we: 1'b1};

   // Chip selected with both byte lanes enabled; only OE/WE vary per state.
   function automatic sram_ctrl_t ldr_ctrl_f(input logic oe, input logic we);
      return '{ce: 1'b0, ub: 1'b0, lb: 1'b0, oe: oe, we: we};
   endfunction

endpackage

// File: rtl/sram_boot_loader_if.sv
// SRAM-style bus bundle. master drives address/controls/write data,
// slave drives read data back.
interface sram_boot_loader_if
   import slc3_mem_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
);
   logic              CE;
   logic              UB;
   logic              LB;
   logic              OE;
   logic              WE;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] Data_write;
   logic [DATA_W-1:0] Data_read;

   modport master (output CE, UB, LB, OE, WE, ADDR, Data_write, input Data_read);
   modport slave  (input CE, UB, LB, OE, WE, ADDR, Data_write, output Data_read);
endinterface

// File: rtl/sram_bus_mux.sv
// Combinational owner select for the SRAM pins: loader bundle while Hold,
// CPU bundle otherwise.
module sram_bus_mux
   import slc3_mem_pkg::*;
#(
   parameter int ADDR_W = SRAM_ADDR_W,
   parameter int DATA_W = SRAM_DATA_W
) (
   input  logic              hold,
   input  sram_ctrl_t        cpu_ctrl,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  sram_ctrl_t        ldr_ctrl,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output sram_ctrl_t        bus_ctrl,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata
);
   assign bus_ctrl  = hold ? ldr_ctrl  : cpu_ctrl;
   assign bus_addr  = hold ? ldr_addr  : cpu_addr;
   assign bus_wdata = hold ? ldr_wdata : cpu_wdata;
endmodule

// File: rtl/sram_boot_loader.sv
// Boot-time ROM-to-SRAM copier that owns the SRAM bus during the load, then
// passes the CPU through. SRAM_LOAD_VERIFY_EN adds a read-back verify pass.
module sram_boot_loader
   import slc3_mem_pkg::*;
#(
   parameter int                ADDR_W      = SRAM_ADDR_W,
   parameter int                DATA_W      = SRAM_DATA_W,
   parameter int                INIT_WORDS  = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                WAIT_CYCLES = 1
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   sram_boot_loader_if.slave  cpu,
   sram_boot_loader_if.master sram,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [DATA_W-1:0]  rom_data,
   output logic               Hold,
   output logic               Busy,
   output logic               Done,
   output logic               Error
);
   localparam int                WC_W     = $clog2(WAIT_CYCLES + 2);
   localparam logic [WC_W-1:0]   LAST_WC  = WC_W'(WAIT_CYCLES);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(INIT_WORDS - 1);

   loader_state_t     state, state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic [WC_W-1:0]   wcnt, wcnt_nxt;
   logic              done_nxt;
   logic [DATA_W-1:0] wdata_p1;
   sram_ctrl_t        ldr_ctrl, cpu_ctrl, bus_ctrl;
   logic [DATA_W-1:0] ldr_wdata;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= ST_IDLE;
         idx   <= '0;
         wcnt  <= '0;
         Done  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         wcnt  <= wcnt_nxt;
         Done  <= done_nxt;
      end
   end

   // p1: ROM word captured on the first WRITE cycle, held through RECOVER
   always_ff @(posedge Clk) begin
      if (state == ST_WRITE && wcnt == '0) wdata_p1 <= rom_data;
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      wcnt_nxt  = '0;
      done_nxt  = Done;
      ldr_ctrl  = CTRL_IDLE;
      ldr_wdata = wdata_p1;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               state_nxt = ST_FETCH;
               idx_nxt   = '0;
               done_nxt  = 1'b0;
            end
         end
         ST_FETCH: begin
            ldr_ctrl  = ldr_ctrl_f(1'b1, 1'b1);
            state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            ldr_ctrl = ldr_ctrl_f(1'b1, 1'b0);
            // Register not yet loaded on the first cycle; the ROM output is already valid.
            if (wcnt == '0) ldr_wdata = rom_data;
            if (wcnt == LAST_WC) state_nxt = ST_RECOVER;
            else                 wcnt_nxt  = wcnt + 1'b1;
         end
         ST_RECOVER: begin
            ldr_ctrl = ldr_ctrl_f(1'b1, 1'b1);
            if (idx == LAST_IDX) begin
`ifdef SRAM_LOAD_VERIFY_EN
               state_nxt = ST_VFETCH;
               idx_nxt   = '0;
`else
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
`endif
            end else begin
               state_nxt = ST_FETCH;
               idx_nxt   = idx + 1'b1;
            end
         end
`ifdef SRAM_LOAD_VERIFY_EN
         ST_VFETCH: begin
            ldr_ctrl  = ldr_ctrl_f(1'b1, 1'b1);
            state_nxt = ST_VREAD;
         end
         ST_VREAD: begin
            ldr_ctrl = ldr_ctrl_f(1'b0, 1'b1);
            if (wcnt != LAST_WC) begin
               wcnt_nxt = wcnt + 1'b1;
            end else if (idx == LAST_IDX) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = ST_VFETCH;
               idx_nxt   = idx + 1'b1;
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef SRAM_LOAD_VERIFY_EN
   logic err_r;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         err_r <= 1'b0;
      else if ((state == ST_IDLE || state == ST_DONE) && Start)
         err_r <= 1'b0;
      else if (state == ST_VREAD && wcnt == LAST_WC && sram.Data_read != rom_data)
         err_r <= 1'b1;
   end

   assign Error = err_r;
`else
   assign Error = 1'b0;
`endif

   assign Hold     = (state != ST_IDLE) && (state != ST_DONE);
   assign Busy     = Hold;
   assign rom_addr = idx;
   assign cpu_ctrl = '{ce: cpu.CE, ub: cpu.UB, lb: cpu.LB, oe: cpu.OE, we: cpu.WE};

   sram_bus_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
      .hold      (Hold),
      .cpu_ctrl  (cpu_ctrl),
      .cpu_addr  (cpu.ADDR),
      .cpu_wdata (cpu.Data_write),
      .ldr_ctrl  (ldr_ctrl),
      .ldr_addr  (BASE_ADDR + idx),
      .ldr_wdata (ldr_wdata),
      .bus_ctrl  (bus_ctrl),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata)
   );

   assign sram.CE         = bus_ctrl.ce;
   assign sram.UB         = bus_ctrl.ub;
   assign sram.LB         = bus_ctrl.lb;
   assign sram.OE         = bus_ctrl.oe;
   assign sram.WE         = bus_ctrl.we;
   assign sram.ADDR       = bus_addr;
   assign sram.Data_write = bus_wdata;
   assign cpu.Data_read   = sram.Data_read;
endmodule

// File: tb/tb_sram_boot_loader.sv
// Directed bench for sram_boot_loader: two loaders (base 0 and base 0xFFFFE)
// sharing clock, reset and Start, each with its own ROM and SRAM model.
module tb_sram_boot_loader;
   import slc3_mem_pkg::*;

   localparam int AW = 20;
   localparam int DW = 16;
`ifdef SRAM_LOAD_VERIFY_EN
   localparam int LOAD_CYC = 28;
   localparam logic EXP_ERR = 1'b1;
`else
   localparam int LOAD_CYC = 16;
   localparam logic EXP_ERR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, corrupt;
   logic [AW-1:0] rom_addr0, rom_addr1;
   logic [DW-1:0] rom_data0, rom_data1;
   logic          hold0, busy0, done0, err0;
   logic          hold1, busy1, done1, err1;
   int            checks, errors;

   sram_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) cpu0 ();
   sram_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) sram0 ();
   sram_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) cpu1 ();
   sram_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) sram1 ();

   sram_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .INIT_WORDS(4),
                      .BASE_ADDR(20'h00000), .WAIT_CYCLES(1)) dut0 (
      .Clk(clk), .Reset(rst), .Start(start), .cpu(cpu0.slave), .sram(sram0.master),
      .rom_addr(rom_addr0), .rom_data(rom_data0),
      .Hold(hold0), .Busy(busy0), .Done(done0), .Error(err0));

   sram_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .INIT_WORDS(4),
                      .BASE_ADDR(20'hFFFFE), .WAIT_CYCLES(1)) dut1 (
      .Clk(clk), .Reset(rst), .Start(start), .cpu(cpu1.slave), .sram(sram1.master),
      .rom_addr(rom_addr1), .rom_data(rom_data1),
      .Hold(hold1), .Busy(busy1), .Done(done1), .Error(err1));

   function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
      case (a[1:0])
         2'd0:    return 16'h1111;
         2'd1:    return 16'h2222;
         2'd2:    return 16'h3333;
         default: return 16'h4444;
      endcase
   endfunction

   always @(posedge clk) begin
      rom_data0 <= rom_word(rom_addr0);
      rom_data1 <= rom_word(rom_addr1);
   end

   // SRAM models indexed by the low address nibble; address 2 of the first can be faulted
   logic [15:0] m0 [16];
   logic [15:0] m1 [16];
   always @(posedge clk) begin
      if (!sram0.CE && !sram0.WE)
         m0[sram0.ADDR[3:0]] <= (corrupt && sram0.ADDR == 20'd2) ? 16'hDEAD : sram0.Data_write;
      if (!sram1.CE && !sram1.WE)
         m1[sram1.ADDR[3:0]] <= sram1.Data_write;
   end
   assign sram0.Data_read = m0[sram0.ADDR[3:0]];
   assign sram1.Data_read = m1[sram1.ADDR[3:0]];

   // Log the address at each WE fall and the length of each WE-low pulse
   logic [AW-1:0] aq0[$], aq1[$];
   int            lq0[$];
   logic          wp0 = 1'b1, wp1 = 1'b1;
   int            lc0 = 0;
   always @(negedge clk) begin
      if (!sram0.WE) begin
         if (wp0) aq0.push_back(sram0.ADDR);
         lc0++;
      end else if (!wp0) begin
         lq0.push_back(lc0);
         lc0 = 0;
      end
      wp0 = sram0.WE;
      if (!sram1.WE && wp1) aq1.push_back(sram1.ADDR);
      wp1 = sram1.WE;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cpu_drive(input logic ce, input logic oe, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      cpu0.CE = ce; cpu0.UB = 1'b1; cpu0.LB = 1'b1; cpu0.OE = oe; cpu0.WE = we;
      cpu0.ADDR = addr; cpu0.Data_write = wd;
      cpu1.CE = ce; cpu1.UB = 1'b1; cpu1.LB = 1'b1; cpu1.OE = oe; cpu1.WE = we;
      cpu1.ADDR = addr; cpu1.Data_write = wd;
   endtask

   // Pulse Start, then count edges until Done; cyc is the edge count after the sampling edge
   task automatic run_load(input int restart_at, output int cyc, output int first_we);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      first_we = 0;
      chk("fetch_hold", 32'(hold0), 32'd1);
      chk("fetch_we", 32'(sram0.WE), 32'd1);
      while (!done0 && cyc < 100) begin
         @(posedge clk);
         cyc++;
         #1;
         if (!sram0.WE && first_we == 0) first_we = cyc;
         start = (cyc == restart_at);
      end
   endtask

   int cyc, fw, b0, b1, bl;
   logic [AW-1:0] wrap_addr [4];

   initial begin
      checks = 0; errors = 0;
      corrupt = 1'b0; start = 1'b0;
      wrap_addr[0] = 20'hFFFFE; wrap_addr[1] = 20'hFFFFF;
      wrap_addr[2] = 20'h00000; wrap_addr[3] = 20'h00001;

      // Reset: bus follows the CPU
      cpu_drive(1'b1, 1'b1, 1'b0, 20'h00123, 16'h0000);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", 32'(sram0.WE), 32'd0);
      chk("rst_addr", 32'(sram0.ADDR), 32'h00123);
      chk("rst_hold", 32'(hold0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_error", 32'(err0), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr0), 32'd0);

      @(negedge clk);
      rst = 1'b0;
      cpu_drive(1'b0, 1'b0, 1'b1, 20'h0ABCD, 16'hBEEF);
      @(posedge clk);
      #1;
      chk("pass_addr", 32'(sram0.ADDR), 32'h0ABCD);
      chk("pass_oe", 32'(sram0.OE), 32'd0);
      chk("pass_ce", 32'(sram0.CE), 32'd0);
      chk("pass_wdata", 32'(sram0.Data_write), 32'h0000BEEF);
      cpu_drive(1'b1, 1'b1, 1'b1, 20'h00000, 16'h0000);

      // Plain load
      b0 = aq0.size(); b1 = aq1.size(); bl = lq0.size();
      run_load(-1, cyc, fw);
      chk("load_cycles", 32'(cyc), 32'(LOAD_CYC));
      chk("first_we_cycle", 32'(fw), 32'd1);
      chk("done_hold", 32'(hold0), 32'd0);
      chk("done_busy", 32'(busy0), 32'd0);
      chk("done_error", 32'(err0), 32'd0);
      chk("done1", 32'(done1), 32'd1);
      chk("wr_count0", 32'(aq0.size() - b0), 32'd4);
      chk("wr_count1", 32'(aq1.size() - b1), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("mem0_%0d", k), 32'(m0[k]), 32'(rom_word(AW'(k))));
         chk($sformatf("addr0_%0d", k), 32'(aq0[b0 + k]), 32'(k));
         chk($sformatf("we_len_%0d", k), 32'(lq0[bl + k]), 32'd2);
         chk($sformatf("wrap_addr_%0d", k), 32'(aq1[b1 + k]), 32'(wrap_addr[k]));
         chk($sformatf("mem1_%0d", k), 32'(m1[wrap_addr[k][3:0]]), 32'(rom_word(AW'(k))));
      end

      // Start pulsed mid-load must not restart
      b0 = aq0.size();
      run_load(6, cyc, fw);
      chk("restart_cycles", 32'(cyc), 32'(LOAD_CYC));
      chk("restart_wr_count", 32'(aq0.size() - b0), 32'd4);

      // Reset in the last WRITE cycle of word 2
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("mid_we_low", 32'(sram0.WE), 32'd0);
      chk("mid_rom_addr", 32'(rom_addr0), 32'd2);
      rst = 1'b1;
      #1;
      chk("abort_we", 32'(sram0.WE), 32'd1);
      chk("abort_ce", 32'(sram0.CE), 32'd1);
      chk("abort_oe", 32'(sram0.OE), 32'd1);
      chk("abort_hold", 32'(hold0), 32'd0);
      chk("abort_done", 32'(done0), 32'd0);
      chk("abort_rom_addr", 32'(rom_addr0), 32'd0);
      @(negedge clk) rst = 1'b0;

      b0 = aq0.size();
      run_load(-1, cyc, fw);
      chk("reload_cycles", 32'(cyc), 32'(LOAD_CYC));
      chk("reload_first_addr", 32'(aq0[b0]), 32'd0);
      chk("reload_mem3", 32'(m0[3]), 32'h4444);

      // Faulted SRAM word at address 2
      corrupt = 1'b1;
      run_load(-1, cyc, fw);
      chk("fault_done", 32'(done0), 32'd1);
      chk("fault_mem2", 32'(m0[2]), 32'h0000DEAD);
      chk("fault_error", 32'(err0), 32'(EXP_ERR));
      chk("clean_error1", 32'(err1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: got still running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
